// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback definitions: FSM states, load-width codes, load context.
package rv32i_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_LOAD_WAIT = 2'b01,
        ST_ERROR     = 2'b10
    } wb_state_e;

    localparam logic [1:0] LW_BYTE = 2'b00;
    localparam logic [1:0] LW_HALF = 2'b01;
    localparam logic [1:0] LW_WORD = 2'b10;
    localparam logic [1:0] LW_RSVD = 2'b11;

    // Outstanding load context captured when the load is accepted
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [1:0]       width;
        logic             unsigned_ld;
        logic [1:0]       addr;
    } load_ctx_t;

    // True for a reserved width or an address not aligned to the access size
    function automatic logic load_misaligned(input logic [1:0] width, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (width)
            LW_BYTE: bad = 1'b0;
            LW_HALF: bad = addr[0];
            LW_WORD: bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rv32i_load_extract.sv
// Combinational byte/half/word lane select with sign or zero extension.
module rv32i_load_extract
    import rv32i_pkg::*;
(
    input  logic [1:0]      width,
    input  logic            unsigned_ld,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lane and extend it to a full word
    always_comb begin
        byte_v = 8'h00;
        case (addr)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];

        case (width)
            LW_BYTE: value = unsigned_ld ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
            LW_HALF: value = unsigned_ld ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: retires ALU results, waits for load data, handles redirects.
module rv32i_writeback
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_valid,
    input  logic [REG_W-1:0] alu_rd_idx,
    input  logic [XLEN-1:0]  alu_result,
    input  logic             alu_is_load,
    input  logic [1:0]       alu_load_width,
    input  logic             alu_load_unsigned,
    input  logic             alu_branch_taken,
    input  logic [XLEN-1:0]  alu_branch_target,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [REG_W-1:0] rd_idx,
    output logic [XLEN-1:0]  new_rd,
    output logic [XLEN-1:0]  new_pc,
    output logic             update_pc,
    output logic             stall,
    output logic             misalign,
    output logic             load_err
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    load_ctx_t        ctx_q, ctx_d;
    logic [REG_W-1:0] rd_idx_q, rd_idx_d;
    logic [XLEN-1:0]  new_rd_q, new_rd_d;
    logic [XLEN-1:0]  new_pc_q, new_pc_d;
    logic             update_pc_q, update_pc_d;
    logic             stall_q, stall_d;
    logic             misalign_q, misalign_d;
    logic             load_err_q, load_err_d;
    logic [XLEN-1:0]  load_value;

    rv32i_load_extract u_extract (
        .width       (ctx_q.width),
        .unsigned_ld (ctx_q.unsigned_ld),
        .addr        (ctx_q.addr),
        .rdata       (mem_rdata),
        .value       (load_value)
    );

    // Next-state and next-output logic; writes to x0 leave new_rd untouched
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctx_d       = ctx_q;
        rd_idx_d    = '0;
        new_rd_d    = new_rd_q;
        new_pc_d    = new_pc_q;
        update_pc_d = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (alu_valid) begin
                    if (alu_is_load) begin
                        if (load_misaligned(alu_load_width, alu_result[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            ctx_d.rd          = alu_rd_idx;
                            ctx_d.width       = alu_load_width;
                            ctx_d.unsigned_ld = alu_load_unsigned;
                            ctx_d.addr        = alu_result[1:0];
                            cnt_d             = '0;
                            state_d           = ST_LOAD_WAIT;
                        end
                    end else begin
                        rd_idx_d = alu_rd_idx;
                        if (alu_rd_idx != '0) begin
                            new_rd_d = alu_result;
                        end
                        if (alu_branch_taken) begin
                            update_pc_d = 1'b1;
                            new_pc_d    = alu_branch_target;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // Data arriving on the timeout cycle still completes the load
                if (mem_rvalid) begin
                    rd_idx_d = ctx_q.rd;
                    if (ctx_q.rd != '0) begin
                        new_rd_d = load_value;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LIMIT) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        stall_d    = (state_d != ST_IDLE);
        load_err_d = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctx_q       <= '0;
            rd_idx_q    <= '0;
            new_rd_q    <= '0;
            new_pc_q    <= RESET_VECTOR;
            update_pc_q <= 1'b0;
            stall_q     <= 1'b0;
            misalign_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctx_q       <= ctx_d;
            rd_idx_q    <= rd_idx_d;
            new_rd_q    <= new_rd_d;
            new_pc_q    <= new_pc_d;
            update_pc_q <= update_pc_d;
            stall_q     <= stall_d;
            misalign_q  <= misalign_d;
            load_err_q  <= load_err_d;
        end
    end

    assign rd_idx    = rd_idx_q;
    assign new_rd    = new_rd_q;
    assign new_pc    = new_pc_q;
    assign update_pc = update_pc_q;
    assign stall     = stall_q;
    assign misalign  = misalign_q;
    assign load_err  = load_err_q;

endmodule

// File: doc/rv32i_writeback.md
RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning the new_pc value held out of reset.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum LOAD_WAIT cycles before an error is declared (range 2..255).
REQ-003 SHALL have ports as follows; reset reset_n, synchronous, active-low; clock clk:
  clk  in  1  clock
  reset_n  in  1  synchronous active-low reset
  alu_valid  in  1  ALU stage presents a retiring instruction
  alu_rd_idx  in  5  destination register
  alu_result  in  32  ALU result, or load address when alu_is_load
  alu_is_load  in  1  instruction is a load
  alu_load_width  in  2  00 byte, 01 half, 10 word, 11 reserved
  alu_load_unsigned  in  1  zero-extend (LBU/LHU)
  alu_branch_taken  in  1  redirect PC
  alu_branch_target  in  32  redirect address
  mem_rvalid  in  1  load data valid, one-cycle pulse
  mem_rdata  in  32  load data word
  rd_idx  out  5  register file write index, 0 = no write
  new_rd  out  32  register file write data
  new_pc  out  32  redirect address
  update_pc  out  1  redirect strobe
  stall  out  1  upstream hold
  misalign  out  1  misaligned/reserved load pulse
  load_err  out  1  sticky load timeout error

Function
REQ-004 SHALL implement states IDLE, LOAD_WAIT, ERROR; all outputs SHALL be registered.
REQ-005 stall SHALL equal 1 whenever state is not IDLE; alu_* inputs SHALL be ignored while stall=1; upstream holds and re-presents them.
REQ-006 IDLE, alu_valid=1, alu_is_load=0: next cycle rd_idx=alu_rd_idx, new_rd=alu_result; one-cycle latency.
REQ-007 IDLE, alu_valid=1, alu_is_load=0, alu_branch_taken=1: next cycle update_pc=1 for one cycle, new_pc=alu_branch_target; alu_branch_taken SHALL be ignored when alu_is_load=1.
REQ-008 rd_idx SHALL be 0 in every cycle that does not carry a write; new_rd holds its last value.
REQ-009 IDLE, valid aligned load: capture rd, width, unsigned, alu_result[1:0]; next state LOAD_WAIT; timeout counter cleared.
REQ-010 Misaligned load (half with addr[0]=1, word with addr[1:0]!=0) or width 11: no state change, misalign=1 for one cycle next cycle, rd_idx=0.
REQ-011 LOAD_WAIT, mem_rvalid=1: next cycle rd_idx=captured rd, new_rd=extracted data, state IDLE, stall=0 in the same cycle.
REQ-012 Extraction: byte = mem_rdata[8*addr+7:8*addr]; half = mem_rdata[16*addr[1]+15:16*addr[1]]; sign- or zero-extended to 32 bits per alu_load_unsigned.
REQ-013 Load with rd=0 SHALL still wait for mem_rvalid; rd_idx stays 0.
REQ-014 LOAD_WAIT counter increments each cycle without mem_rvalid; on reaching MEM_TIMEOUT: state ERROR, load_err=1.
REQ-015 mem_rvalid arriving in the cycle the counter reaches MEM_TIMEOUT SHALL win: load completes normally.
REQ-016 ERROR SHALL hold stall=1, load_err=1, rd_idx=0 until reset; mem_rvalid ignored.
REQ-017 mem_rvalid in IDLE or ERROR SHALL be ignored.

Reset
REQ-018 On reset_n=0 at a clk edge: state IDLE, counter 0, rd_idx 0, new_rd 0, new_pc RESET_VECTOR, update_pc 0, stall 0, misalign 0, load_err 0.
REQ-019 Reset during LOAD_WAIT SHALL abandon the load; a mem_rvalid in the first cycle after reset release SHALL be ignored (state IDLE).

Structure
REQ-020 State encodings and load-width codes (LW_BYTE, LW_HALF, LW_WORD, LW_RSVD) SHALL live in a shared rv32i package/include.
REQ-021 Extraction/extension SHALL be a combinational sub-module rv32i_load_extract (inputs width, unsigned, addr[1:0], rdata; output 32-bit value).

Verification
REQ-022 ALU op rd=5, result 32'h1234_5678 -> next cycle rd_idx=5, new_rd=32'h1234_5678, stall=0.
REQ-023 LB rd=3, addr[1:0]=2, rvalid 4 cycles later, rdata=32'h0080_0000 -> stall high 4 cycles, then rd_idx=3, new_rd=32'hFFFF_FF80; same with LBU -> 32'h0000_0080.
REQ-024 LW with addr[1:0]=1 -> misalign pulse one cycle, rd_idx=0, stall=0.
REQ-025 LH, no rvalid for 16 cycles -> load_err=1, stall=1 sticky; later rvalid ignored; reset clears all.
REQ-026 Branch taken target 32'h0000_0100 -> update_pc one cycle, new_pc=32'h0000_0100; same flags on a load -> update_pc stays 0.
REQ-027 Reset asserted mid LOAD_WAIT, rvalid first cycle after release -> rd_idx stays 0, state IDLE.
